// File: rtl/cache_fill_ctrl_if.sv
// Bundle of request, RAM-fetch and cache-array signals for cache_fill_ctrl.
// The slave modport is the controller view and the master modport is the environment view.
interface cache_fill_ctrl_if #(
    parameter int SizeDataMux = 64,
    parameter int AddrWidth   = 32
);
    logic                   rd_miss;
    logic                   wr_req;
    logic [AddrWidth-1:0]   addr;
    logic                   ram_req;
    logic [AddrWidth-1:0]   ram_addr;
    logic                   ram_ack;
    logic [SizeDataMux-1:0] ram_rdata;
    logic [SizeDataMux-1:0] Data_RAM;
    logic                   seleccion;
    logic                   array_we;
    logic [AddrWidth-1:0]   array_addr;
    logic                   busy;
    logic                   done;
    logic                   timeout_err;

    modport slave (
        input  rd_miss, wr_req, addr, ram_ack, ram_rdata,
        output ram_req, ram_addr, Data_RAM, seleccion, array_we,
               array_addr, busy, done, timeout_err
    );

    modport master (
        output rd_miss, wr_req, addr, ram_ack, ram_rdata,
        input  ram_req, ram_addr, Data_RAM, seleccion, array_we,
               array_addr, busy, done, timeout_err
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Sequencer for the cache data-array mux: RAM fill on read miss, CPU write steering, bounded fetch.
// Every output is a flop or a decode of the state flops; requests seen while busy are dropped.
module cache_fill_ctrl #(
    parameter int SizeDataMux   = 64,
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic              clk,
    input  logic              rst,
    cache_fill_ctrl_if.slave  bus
);
    localparam int CntW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [SizeDataMux-1:0] data_q, data_d;
    logic                   sel_q, sel_d;
    logic                   terr_q, terr_d;
    logic                   last_cycle;

    assign last_cycle = (cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            terr_q  <= terr_d;
        end
    end

    // rd_miss has priority over wr_req when both arrive together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.rd_miss)     state_d = REQ;
                else if (bus.wr_req) state_d = WRITE;
            end
            REQ: begin
                if (bus.ram_ack)     state_d = WRITE;
                else if (last_cycle) state_d = IDLE;
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        data_d = data_q;
        sel_d  = sel_q;
        terr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rd_miss) begin
                    addr_d = bus.addr;
                    cnt_d  = '0;
                end else if (bus.wr_req) begin
                    addr_d = bus.addr;
                    sel_d  = 1'b1;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CntW'(1);
                if (bus.ram_ack) begin
                    data_d = bus.ram_rdata;
                    sel_d  = 1'b0;
                end else if (last_cycle) begin
                    terr_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output strobes decode the registered state only, so no input reaches an output in the same cycle.
    always_comb begin
        bus.ram_req     = (state_q == REQ);
        bus.array_we    = (state_q == WRITE);
        bus.done        = (state_q == DONE);
        bus.busy        = (state_q != IDLE);
        bus.ram_addr    = addr_q;
        bus.array_addr  = addr_q;
        bus.Data_RAM    = data_q;
        bus.seleccion   = sel_q;
        bus.timeout_err = terr_q;
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized plus directed bench for cache_fill_ctrl, checked against a transaction-level model.
module tb_cache_fill_ctrl;
    localparam int T = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    bit   mon_en;

    cache_fill_ctrl_if #(.SizeDataMux(64), .AddrWidth(32)) bus ();

    cache_fill_ctrl #(.SizeDataMux(64), .AddrWidth(32), .TimeoutCycles(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a fetch has an age (cycles spent requesting, 1..T); a write tail is two cycles (strobe, done).
    bit          m_fetch;
    int          m_age;
    int          m_tail;
    bit          m_sel;
    bit          m_terr;
    logic [63:0] m_data;
    logic [31:0] m_addr;

    always @(posedge clk) begin
        if (rst) begin
            m_fetch = 0; m_age = 0; m_tail = 0; m_sel = 0; m_terr = 0;
            m_data = '0; m_addr = '0;
        end else begin
            m_terr = 0;
            if (m_fetch) begin
                if (bus.ram_ack) begin
                    m_data  = bus.ram_rdata;
                    m_sel   = 0;
                    m_fetch = 0;
                    m_tail  = 2;
                end else if (m_age == T) begin
                    m_fetch = 0;
                    m_terr  = 1;
                end else begin
                    m_age++;
                end
            end else if (m_tail > 0) begin
                m_tail--;
            end else if (bus.rd_miss) begin
                m_fetch = 1;
                m_age   = 1;
                m_addr  = bus.addr;
            end else if (bus.wr_req) begin
                m_tail  = 2;
                m_sel   = 1;
                m_addr  = bus.addr;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_val("ram_req",     bus.ram_req,     m_fetch);
            check_val("array_we",    bus.array_we,    m_tail == 2);
            check_val("done",        bus.done,        m_tail == 1);
            check_val("busy",        bus.busy,        m_fetch || (m_tail > 0));
            check_val("timeout_err", bus.timeout_err, m_terr);
            check_val("seleccion",   bus.seleccion,   m_sel);
            check_val("Data_RAM",    bus.Data_RAM,    m_data);
            check_val("ram_addr",    bus.ram_addr,    m_addr);
            check_val("array_addr",  bus.array_addr,  m_addr);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.rd_miss = 0; bus.wr_req = 0; bus.ram_ack = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && bus.busy; i++) tick();
        check_val("wait_idle", bus.busy, 1'b0);
    endtask

    initial begin
        int n_req, n_we, n_done, terr_cyc;
        int ack_mod;
        n_checks = 0; n_errors = 0; mon_en = 0;
        rst = 1; bus.addr = '0; bus.ram_rdata = '0;
        clear_inputs();
        tick(); tick();
        rst = 0; mon_en = 1;
        tick();
        check_val("rst_busy", bus.busy, 1'b0);
        check_val("rst_data", bus.Data_RAM, 64'h0);

        // Fill with ack at cycle 3.
        bus.rd_miss = 1; bus.addr = 32'h100;
        tick(); clear_inputs();
        check_val("fill_req_c1", bus.ram_req, 1'b1);
        tick(); tick();
        bus.ram_ack = 1; bus.ram_rdata = 64'hDEADBEEF_CAFEF00D;
        tick(); clear_inputs();
        check_val("fill_we_c4",   bus.array_we, 1'b1);
        check_val("fill_data_c4", bus.Data_RAM, 64'hDEADBEEF_CAFEF00D);
        check_val("fill_aadr_c4", bus.array_addr, 32'h100);
        check_val("fill_sel_c4",  bus.seleccion, 1'b0);
        check_val("fill_req_c4",  bus.ram_req, 1'b0);
        tick();
        check_val("fill_done_c5", bus.done, 1'b1);
        tick();
        check_val("fill_idle_c6", bus.busy, 1'b0);

        // CPU write.
        bus.wr_req = 1; bus.addr = 32'h208;
        tick(); clear_inputs();
        check_val("wr_sel_c1",  bus.seleccion, 1'b1);
        check_val("wr_we_c1",   bus.array_we, 1'b1);
        check_val("wr_req_c1",  bus.ram_req, 1'b0);
        check_val("wr_data_c1", bus.Data_RAM, 64'hDEADBEEF_CAFEF00D);
        tick();
        check_val("wr_done_c2", bus.done, 1'b1);
        wait_idle();

        // Simultaneous rd_miss and wr_req: fill wins.
        bus.rd_miss = 1; bus.wr_req = 1; bus.addr = 32'h300;
        tick(); clear_inputs();
        check_val("both_req", bus.ram_req, 1'b1);
        bus.ram_ack = 1; bus.ram_rdata = 64'h0123_4567_89AB_CDEF;
        tick(); clear_inputs();
        check_val("both_we",  bus.array_we, 1'b1);
        check_val("both_sel", bus.seleccion, 1'b0);
        wait_idle();

        // Timeout with no ack.
        bus.rd_miss = 1; bus.addr = 32'h400;
        n_req = 0; n_we = 0; terr_cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            tick(); clear_inputs();
            if (bus.ram_req) n_req++;
            if (bus.array_we) n_we++;
            if (bus.timeout_err) terr_cyc = c;
        end
        check_val("to_req_cycles", n_req, T);
        check_val("to_err_cycle",  terr_cyc, T + 1);
        check_val("to_no_we",      n_we, 0);

        // Ack on the last allowed cycle.
        bus.rd_miss = 1; bus.addr = 32'h500;
        for (int c = 1; c <= T; c++) begin
            tick(); clear_inputs();
        end
        bus.ram_ack = 1; bus.ram_rdata = 64'hA5A5_5A5A_0F0F_F0F0;
        tick(); clear_inputs();
        check_val("late_ack_we",   bus.array_we, 1'b1);
        check_val("late_ack_terr", bus.timeout_err, 1'b0);
        wait_idle();

        // Reset during REQ; late ack ignored.
        bus.rd_miss = 1; bus.addr = 32'h600;
        tick(); clear_inputs();
        tick();
        rst = 1;
        tick();
        rst = 0; bus.ram_ack = 1; bus.ram_rdata = 64'h1111_2222_3333_4444;
        n_we = 0; n_done = 0;
        check_val("rst_mid_req",  bus.ram_req, 1'b0);
        check_val("rst_mid_addr", bus.ram_addr, 32'h0);
        for (int c = 0; c < 6; c++) begin
            tick(); clear_inputs();
            if (bus.array_we) n_we++;
            if (bus.done) n_done++;
        end
        check_val("rst_mid_no_we",   n_we, 0);
        check_val("rst_mid_no_done", n_done, 0);

        // wr_req while busy is dropped.
        bus.rd_miss = 1; bus.addr = 32'h700;
        n_we = 0; n_done = 0;
        for (int c = 1; c <= 12; c++) begin
            tick(); clear_inputs();
            if (c == 2) bus.wr_req = 1;
            if (c == 3) bus.ram_ack = 1;
            if (bus.array_we) n_we++;
            if (bus.done) n_done++;
        end
        check_val("busy_wr_we",   n_we, 1);
        check_val("busy_wr_done", n_done, 1);

        // Random traffic.
        ack_mod = 2;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i % 500 == 0) ack_mod = (ack_mod == 2) ? 40 : 2;
            rst           = ($urandom_range(0, 299) == 0);
            bus.rd_miss   = ($urandom_range(0, 7) == 0);
            bus.wr_req    = ($urandom_range(0, 7) == 0);
            bus.ram_ack   = ($urandom_range(0, ack_mod) == 0);
            bus.addr      = $urandom;
            bus.ram_rdata = {$urandom, $urandom};
        end
        tick();
        rst = 0; clear_inputs();
        tick(); tick();
        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Sequencer that feeds the 64-bit CPU/RAM data mux in front of the cache data array. On a read miss it fetches one word from RAM over a req/ack handshake, registers it onto the mux's RAM input and writes it into the array. On a CPU write it steers the mux to the CPU data and issues the array write. It owns the mux select line and the array write strobe, and bounds each RAM fetch with a timeout counter.

## Interface
- SizeDataMux, 64, data width; matches the downstream mux width
- AddrWidth, 32, address width
- TimeoutCycles, 16, maximum number of cycles spent in REQ waiting for ram_ack (≥1)
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous and active-high
- rd_miss  in  1  read-miss fill request; sampled only when busy=0
- wr_req  in  1  CPU write request; sampled only when busy=0
- addr  in  AddrWidth  request address; latched on acceptance
- ram_req  out  1  RAM fetch request, held high until ack or timeout
- ram_addr  out  AddrWidth  latched address presented to RAM
- ram_ack  in  1  RAM data valid this cycle
- ram_rdata  in  SizeDataMux  RAM read data, valid with ram_ack
- Data_RAM  out  SizeDataMux  registered fill word, drives the mux RAM input
- seleccion  out  1  mux select: 1 = CPU data, 0 = RAM data
- array_we  out  1  one-cycle cache-array write strobe
- array_addr  out  AddrWidth  latched address for the array write
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- timeout_err  out  1  one-cycle pulse when a fetch is abandoned

## Operation
- States: IDLE, REQ, WRITE, DONE.
- IDLE:
  - rd_miss=1: latch addr, clear the counter, go to REQ. rd_miss wins if rd_miss and wr_req are both high.
  - wr_req=1 (no rd_miss): latch addr, set seleccion=1, go to WRITE.
  - Requests are pulses. Requests arriving while busy=1 are dropped, not queued.
- REQ:
  - ram_req=1 and ram_addr=latched address. The counter increments each cycle.
  - ram_ack=1: load Data_RAM←ram_rdata, set seleccion=0, go to WRITE.
  - Otherwise, if counter=TimeoutCycles−1: go to IDLE and pulse timeout_err for one cycle. Data_RAM and seleccion are left unchanged, and no array write is issued.
  - ram_ack on the final allowed cycle wins over the timeout.
- WRITE: array_we=1 for exactly one cycle, array_addr=latched address, seleccion held. Then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- seleccion and Data_RAM are registers. They hold their last value outside WRITE, so the downstream mux output stays stable through the array write.
- ram_req is deasserted in the cycle after ack or timeout. ram_req never overlaps array_we.
- Reset values: state=IDLE; ram_req=0, array_we=0, done=0, timeout_err=0, busy=0, seleccion=0; Data_RAM, ram_addr and array_addr all 0; counter=0.
- Reset mid-operation: on the next edge all of the above return to their reset values. An outstanding fetch is abandoned with no array_we and no done; a late ram_ack after reset is ignored.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Read fill, rd_miss accepted at cycle 0:
  - ram_req high from cycle 1.
  - ram_ack at cycle k (k≥1): Data_RAM valid and array_we high at cycle k+1, done at k+2, busy=0 at k+3.
  - Zero-wait ack (k=1): array_we at 2, done at 3.
- CPU write, wr_req accepted at cycle 0: seleccion=1 and array_we at cycle 1, done at 2, busy=0 at 3.
- Timeout: with no ack, ram_req is high for cycles 1..TimeoutCycles. timeout_err and busy=0 at cycle TimeoutCycles+1.
- Back-to-back: a new request is accepted in the first cycle busy=0, with no extra dead cycle.

## Test plan
- Reset, then rd_miss with addr=0x100; ram_ack at cycle 3 with ram_rdata=0xDEADBEEF_CAFEF00D -> ram_req high cycles 1–3, Data_RAM=0xDEADBEEF_CAFEF00D with seleccion=0 and array_we=1 (array_addr=0x100) at cycle 4, done at 5.
- wr_req with addr=0x208 -> seleccion=1 and array_we at cycle 1, done at 2; ram_req never asserted; Data_RAM unchanged.
- rd_miss and wr_req in the same cycle -> fill path taken, seleccion=0 at write; the write request is dropped.
- rd_miss with no ram_ack, TimeoutCycles=16 -> ram_req high for exactly 16 cycles, timeout_err pulse at cycle 17, no array_we, Data_RAM unchanged. Repeat with ack on cycle 16 -> normal fill, no timeout_err.
- rst asserted in cycle 2 of REQ, ram_ack at cycle 3 -> every output at its reset value from cycle 3, no array_we, no done.
- wr_req pulsed while busy during a fill -> ignored; exactly one array_we and one done.
